// File: rtl/weight_dispatcher_if.sv
// Weight stream from the dispatcher to the PE array.
// Valid/ready handshake with row, pass and last tags.
interface weight_dispatcher_if #(
    parameter int ROW_W  = 88,
    parameter int IDX_W  = 6,
    parameter int PASS_W = 8
);
    logic              pe_w_valid;
    logic              pe_w_ready;
    logic [ROW_W-1:0]  pe_w_data;
    logic [IDX_W-1:0]  pe_w_row;
    logic [PASS_W-1:0] pe_w_pass;
    logic              pe_w_last;

    modport master (
        output pe_w_valid,
        output pe_w_data,
        output pe_w_row,
        output pe_w_pass,
        output pe_w_last,
        input  pe_w_ready
    );

    modport slave (
        input  pe_w_valid,
        input  pe_w_data,
        input  pe_w_row,
        input  pe_w_pass,
        input  pe_w_last,
        output pe_w_ready
    );
endinterface

// File: rtl/weight_dispatcher.sv
// Streams a full weight buffer to the PE array for N passes,
// then pulses free_weight_buffer so the buffer refetches.
package weight_dispatcher_pkg;
    typedef enum logic [1:0] {
        MODE1 = 2'd0,
        MODE2 = 2'd1,
        MODE3 = 2'd2,
        MODE4 = 2'd3
    } op_mode_e;
endpackage

module weight_dispatcher
    import weight_dispatcher_pkg::*;
#(
    parameter int ROW_W  = 88,
    parameter int IDX_W  = 6,
    parameter int PASS_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  op_mode_e           mode_in,
    input  logic [PASS_W-1:0]  pass_count,
    input  logic               buf_ready,
    output logic [IDX_W-1:0]   buf_rd_idx,
    input  logic [ROW_W-1:0]   buf_rd_data,
    weight_dispatcher_if.master pe,
    output logic               free_weight_buffer,
    output logic               busy
);
    localparam int NARROW_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        RELEASE
    } state_e;

    state_e            state_q, state_d;
    op_mode_e          mode_q, mode_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic [IDX_W-1:0]  row_q, row_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              vld_q, vld_d;
    logic [ROW_W-1:0]  data_q, data_d;
    logic [IDX_W-1:0]  orow_q, orow_d;
    logic [PASS_W-1:0] opass_q, opass_d;
    logic              last_q, last_d;

    logic [IDX_W-1:0]  rows_n;
    logic              narrow;
    logic              last_row;
    logic              final_pass;
    logic              load;

    always_comb begin
        rows_n = IDX_W'(44);
        narrow = 1'b0;
        unique case (mode_q)
            MODE3: begin
                rows_n = IDX_W'(20);
                narrow = 1'b1;
            end
            MODE4: begin
                rows_n = IDX_W'(12);
                narrow = 1'b1;
            end
            default: begin
                rows_n = IDX_W'(44);
                narrow = 1'b0;
            end
        endcase
    end

    assign last_row   = (row_q == rows_n - IDX_W'(1));
    assign final_pass = (pass_q == passes_q - PASS_W'(1));

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        passes_d = passes_q;
        row_d    = row_q;
        pass_d   = pass_q;
        vld_d    = vld_q;
        data_d   = data_q;
        orow_d   = orow_q;
        opass_d  = opass_q;
        last_d   = last_q;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (buf_ready) begin
                    mode_d   = mode_in;
                    passes_d = (pass_count == '0) ? PASS_W'(1)
                                                  : pass_count;
                    row_d    = '0;
                    pass_d   = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                load = !vld_q || pe.pe_w_ready;
                if (load) begin
                    vld_d   = 1'b1;
                    data_d  = narrow
                            ? {{(ROW_W-NARROW_W){1'b0}},
                               buf_rd_data[NARROW_W-1:0]}
                            : buf_rd_data;
                    orow_d  = row_q;
                    opass_d = pass_q;
                    last_d  = last_row;
                    if (last_row) begin
                        row_d  = '0;
                        pass_d = pass_q + PASS_W'(1);
                        if (final_pass) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        row_d = row_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (vld_q && pe.pe_w_ready) begin
                    vld_d   = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= MODE1;
            passes_q <= '0;
            row_q    <= '0;
            pass_q   <= '0;
            vld_q    <= 1'b0;
            data_q   <= '0;
            orow_q   <= '0;
            opass_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            passes_q <= passes_d;
            row_q    <= row_d;
            pass_q   <= pass_d;
            vld_q    <= vld_d;
            data_q   <= data_d;
            orow_q   <= orow_d;
            opass_q  <= opass_d;
            last_q   <= last_d;
        end
    end

    assign buf_rd_idx         = row_q;
    assign pe.pe_w_valid      = vld_q;
    assign pe.pe_w_data       = data_q;
    assign pe.pe_w_row        = orow_q;
    assign pe.pe_w_pass       = opass_q;
    assign pe.pe_w_last       = last_q;
    assign free_weight_buffer = (state_q == RELEASE);
    assign busy               = (state_q != IDLE);
endmodule

// File: tb/tb_weight_dispatcher.sv
// Scoreboard bench: jobs push expected beats, a negedge monitor
// pops and compares every handshake, hold and release pulse.
module tb_weight_dispatcher;
    import weight_dispatcher_pkg::*;

    localparam int ROW_W  = 88;
    localparam int IDX_W  = 6;
    localparam int PASS_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    op_mode_e          mode_in = MODE1;
    logic [PASS_W-1:0] pass_count = '0;
    logic              buf_ready = 1'b0;
    logic [IDX_W-1:0]  buf_rd_idx;
    logic [ROW_W-1:0]  buf_rd_data;
    logic              free;
    logic              busy;

    logic [ROW_W-1:0]  mem [44];

    weight_dispatcher_if #(
        .ROW_W(ROW_W), .IDX_W(IDX_W), .PASS_W(PASS_W)
    ) pe_if ();

    weight_dispatcher #(
        .ROW_W(ROW_W), .IDX_W(IDX_W), .PASS_W(PASS_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mode_in           (mode_in),
        .pass_count        (pass_count),
        .buf_ready         (buf_ready),
        .buf_rd_idx        (buf_rd_idx),
        .buf_rd_data       (buf_rd_data),
        .pe                (pe_if.master),
        .free_weight_buffer(free),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    assign buf_rd_data = (buf_rd_idx < 6'd44) ? mem[buf_rd_idx] : '0;

    typedef struct {
        logic [ROW_W-1:0]  data;
        logic [IDX_W-1:0]  row;
        logic [PASS_W-1:0] pass;
        logic              last;
        logic              fin;
    } beat_t;

    beat_t exp_q[$];
    int    compared = 0;
    int    mismatched = 0;
    int    rdy_mode = 0;
    bit    mon_en = 1'b0;

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // PE-side ready generator: always, 1-0-0-1 pattern, or random
    initial begin
        int ph;
        ph = 0;
        pe_if.pe_w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: pe_if.pe_w_ready = 1'b1;
                1: begin
                    pe_if.pe_w_ready = (ph % 4 == 0) || (ph % 4 == 3);
                    ph++;
                end
                default: pe_if.pe_w_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    beat_t held;
    bit    hold_pend = 1'b0;
    bit    exp_free = 1'b0;
    bit    prev_free = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        if (mon_en) begin
            if (hold_pend) begin
                chk("hold_valid", 96'(pe_if.pe_w_valid), 96'(1));
                chk("hold_data", 96'(pe_if.pe_w_data), 96'(held.data));
                chk("hold_row", 96'(pe_if.pe_w_row), 96'(held.row));
                chk("hold_pass", 96'(pe_if.pe_w_pass), 96'(held.pass));
                chk("hold_last", 96'(pe_if.pe_w_last), 96'(held.last));
            end
            if (free || exp_free)
                chk("free_pulse", 96'(free), 96'(exp_free));
            if (prev_free)
                chk("busy_after_free", 96'(busy), 96'(0));
            prev_free = free;
            exp_free = 1'b0;
            if (pe_if.pe_w_valid && pe_if.pe_w_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 96'(pe_if.pe_w_row), 96'hEEE);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 96'(pe_if.pe_w_data), 96'(e.data));
                    chk("beat_row", 96'(pe_if.pe_w_row), 96'(e.row));
                    chk("beat_pass", 96'(pe_if.pe_w_pass), 96'(e.pass));
                    chk("beat_last", 96'(pe_if.pe_w_last), 96'(e.last));
                    exp_free = e.fin;
                end
            end
            hold_pend = pe_if.pe_w_valid && !pe_if.pe_w_ready;
            held.data = pe_if.pe_w_data;
            held.row  = pe_if.pe_w_row;
            held.pass = pe_if.pe_w_pass;
            held.last = pe_if.pe_w_last;
            held.fin  = 1'b0;
        end
    end

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_valid"}, 96'(pe_if.pe_w_valid), 96'(0));
        chk({nm, "_data"}, 96'(pe_if.pe_w_data), 96'(0));
        chk({nm, "_row"}, 96'(pe_if.pe_w_row), 96'(0));
        chk({nm, "_pass"}, 96'(pe_if.pe_w_pass), 96'(0));
        chk({nm, "_last"}, 96'(pe_if.pe_w_last), 96'(0));
        chk({nm, "_idx"}, 96'(buf_rd_idx), 96'(0));
        chk({nm, "_free"}, 96'(free), 96'(0));
        chk({nm, "_busy"}, 96'(busy), 96'(0));
    endtask

    // Reference: N rows per pass by mode, max(pc,1) passes,
    // narrow modes keep only the low 64 bits of each row.
    task automatic load_job(input op_mode_e m, input logic [7:0] pc,
                            output int n, output int p);
        beat_t       b;
        logic [95:0] r96;
        n = (m == MODE3) ? 20 : (m == MODE4) ? 12 : 44;
        p = (pc == 0) ? 1 : int'(pc);
        for (int r = 0; r < 44; r++) begin
            r96 = {$urandom, $urandom, $urandom};
            mem[r] = r96[ROW_W-1:0];
        end
        for (int pi = 0; pi < p; pi++) begin
            for (int r = 0; r < n; r++) begin
                b.data = mem[r];
                if (n < 44) b.data[ROW_W-1:64] = '0;
                b.row  = IDX_W'(r);
                b.pass = PASS_W'(pi);
                b.last = (r == n - 1);
                b.fin  = (pi == p - 1) && (r == n - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic start_job(input op_mode_e m, input logic [7:0] pc);
        int lat;
        @(posedge clk);
        #1;
        mode_in = m;
        pass_count = pc;
        buf_ready = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pe_if.pe_w_valid) break;
            lat++;
        end
        chk("first_valid_latency", 96'(lat), 96'(2));
    endtask

    task automatic run_job(input op_mode_e m, input logic [7:0] pc,
                           input bit chg);
        int n, p, cyc;
        bit done;
        load_job(m, pc, n, p);
        start_job(m, pc);
        pass_count = 8'($urandom);
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (chg && pe_if.pe_w_valid && pe_if.pe_w_row == 6'd10)
                mode_in = MODE4;
            if (free) done = 1'b1;
        end
        #1;
        buf_ready = 1'b0;
        if (!done) begin
            chk("job_timeout", 96'(cyc), 96'(0));
            exp_q.delete();
        end else begin
            chk("queue_drained", 96'(exp_q.size()), 96'(0));
            if (rdy_mode == 0)
                chk("free_cycle", 96'(cyc + 2), 96'(n * p + 2));
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic abort_job();
        int n, p, cyc;
        load_job(MODE1, 8'd1, n, p);
        start_job(MODE1, 8'd1);
        cyc = 0;
        while (!(pe_if.pe_w_valid && pe_if.pe_w_row == 6'd25)
               && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_row25", 96'(pe_if.pe_w_row), 96'(25));
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        exp_q.delete();
        buf_ready = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_free", 96'(free), 96'(0));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;

        rdy_mode = 0;
        run_job(MODE1, 8'd1, 1'b0);
        run_job(MODE4, 8'd3, 1'b0);
        run_job(MODE3, 8'd0, 1'b0);
        rdy_mode = 1;
        run_job(MODE2, 8'd1, 1'b0);
        rdy_mode = 0;
        run_job(MODE1, 8'd1, 1'b1);
        run_job(MODE4, 8'd1, 1'b0);
        abort_job();
        run_job(MODE1, 8'd1, 1'b0);
        rdy_mode = 2;
        for (int j = 0; j < 6; j++) begin
            run_job(op_mode_e'($urandom_range(0, 3)),
                    8'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
